// File: rtl/ntt_cmd_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ntt_cmd_sequencer_pkg
//   Shared definitions for the NTT host-side command sequencer.
//   - NTT core opcode constants (the values driven on OP_CODE by the host).
//   - State encoding for the sequencer FSM.
// ---------------------------------------------------------------------------
package ntt_cmd_sequencer_pkg;

  // NTT core opcodes
  localparam logic [4:0] LD_PARAM   = 5'b00001;
  localparam logic [4:0] LD_W       = 5'b00010;
  localparam logic [4:0] LD_DATA    = 5'b00011;
  localparam logic [4:0] NTT_START  = 5'b00100;
  localparam logic [4:0] INTT_START = 5'b00111;
  localparam logic [4:0] RD_INTT    = 5'b01000;
  localparam logic [4:0] PWM_START  = 5'b01010;
  localparam logic [4:0] RD_NTT     = 5'b01011;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OP   = 3'd1,
    ST_DATA = 3'd2,
    ST_GAP  = 3'd3,
    ST_WAIT = 3'd4
  } seq_state_t;

endpackage

// File: rtl/ntt_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// ntt_cmd_sequencer
//   Drives the NTT core load protocol from a command port and a data stream:
//   a one-cycle opcode pulse, a data phase of cmd_len cycles (stream words or
//   strobe-only), a one-cycle idle gap, and an optional wait for the core's
//   done rising edge (with timeout).
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op                opcode to issue (passed through unchecked)
//   cmd_len               data-phase length in cycles (0 = no data phase)
//   cmd_strobe            data phase drives din_valid=1, din0=0, no stream use
//   cmd_wait              wait for done rising edge after the gap
//   s_valid/s_ready       data stream handshake
//   s_data                data word
//   OP_CODE               core opcode (registered, one-cycle pulse)
//   din_valid, din0       core data strobe / data (registered)
//   done                  core completion level
//   busy                  sequencer not idle
//   tmo                   sticky done-wait timeout, cleared on command accept
// ---------------------------------------------------------------------------
module ntt_cmd_sequencer
  import ntt_cmd_sequencer_pkg::*;
#(
  parameter int DW   = 32,
  parameter int OPW  = 5,
  parameter int LENW = 12,
  parameter int TMOW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OPW-1:0]  cmd_op,
  input  logic [LENW-1:0] cmd_len,
  input  logic            cmd_strobe,
  input  logic            cmd_wait,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  output logic [OPW-1:0]  OP_CODE,
  output logic            din_valid,
  output logic [DW-1:0]   din0,
  input  logic            done,
  output logic            busy,
  output logic            tmo
);

  // Timeout fires on the WAIT cycle whose increment would reach all-ones,
  // i.e. after 2**TMOW-1 WAIT cycles.
  localparam logic [TMOW-1:0] TMO_LAST = ~TMOW'(1);

  seq_state_t      state;
  logic [LENW-1:0] len_q;
  logic            strobe_q;
  logic            wait_q;
  logic [LENW-1:0] cnt;
  logic [TMOW-1:0] tmo_cnt;
  logic            done_q;
  logic            accept;

  // Handshake readies depend on state only. A no-wait command may be
  // followed immediately: the next command is taken in the GAP cycle.
  assign cmd_ready = !reset && ((state == ST_IDLE) ||
                                ((state == ST_GAP) && !wait_q));
  assign s_ready   = (state == ST_DATA) && !strobe_q;
  assign busy      = (state != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      strobe_q  <= 1'b0;
      wait_q    <= 1'b0;
      cnt       <= '0;
      tmo_cnt   <= '0;
      done_q    <= 1'b0;
      tmo       <= 1'b0;
      OP_CODE   <= '0;
      din_valid <= 1'b0;
      din0      <= '0;
    end else begin
      done_q    <= done;
      // Core outputs are single-cycle unless re-driven below.
      OP_CODE   <= '0;
      din_valid <= 1'b0;
      din0      <= '0;

      if (accept) begin
        // Opcode is registered on the accept edge so the pulse appears in
        // the OP-state cycle itself.
        len_q    <= cmd_len;
        strobe_q <= cmd_strobe;
        wait_q   <= cmd_wait;
        tmo      <= 1'b0;
        OP_CODE  <= cmd_op;
        state    <= ST_OP;
      end else begin
        unique case (state)
          ST_IDLE: ;

          ST_OP: begin
            cnt   <= len_q;
            state <= (len_q != '0) ? ST_DATA : ST_GAP;
          end

          ST_DATA: begin
            if (strobe_q || s_valid) begin
              din_valid <= 1'b1;
              din0      <= strobe_q ? '0 : s_data;
              cnt       <= cnt - LENW'(1);
              if (cnt == LENW'(1)) state <= ST_GAP;
            end
          end

          ST_GAP: begin
            tmo_cnt <= '0;
            state   <= wait_q ? ST_WAIT : ST_IDLE;
          end

          ST_WAIT: begin
            // done_q tracks done every cycle, so a level already high on
            // entry is not mistaken for a completion edge.
            if (done && !done_q) begin
              state <= ST_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TMOW'(1);
              if (tmo_cnt == TMO_LAST) begin
                tmo   <= 1'b1;
                state <= ST_IDLE;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
